// File: rtl/rx_lane_sync_ctrl.sv
// rx_lane_sync_ctrl: per-lane RX lock sequencer.
// Each lane waits for gearbox block-lock, releases descrambler passthrough,
// and times meta-frame lock acquisition. It retries after a timeout or a loss
// of lock, and reports per-lane and all-lanes-up status.
// Optional feature: define LANE_SYNC_RETRY_CNT_EN to add per-lane 8-bit
// saturating retry counters on output RETRY_CNT.
module rx_lane_sync_ctrl #(
  parameter int NUM_LANES      = 4,
  parameter int LOCK_TIMEOUT   = 2048,
  parameter int HOLDOFF_CYCLES = 64
) (
  input  logic                   USER_CLK,
  input  logic                   SYSTEM_RESET,
  input  logic                   ENABLE,
  input  logic [NUM_LANES-1:0]   BLOCK_LOCK,
  input  logic [NUM_LANES-1:0]   DESCR_LOCKED,
  input  logic                   CLEAR_STICKY,
  output logic [NUM_LANES-1:0]   PASSTHROUGH,
  output logic [NUM_LANES-1:0]   LANE_UP,
  output logic                   ALL_LANES_UP,
  output logic [NUM_LANES-1:0]   LOCK_LOSS
`ifdef LANE_SYNC_RETRY_CNT_EN
  ,
  output logic [8*NUM_LANES-1:0] RETRY_CNT
`endif
);

  localparam int TMAX = (LOCK_TIMEOUT > HOLDOFF_CYCLES) ? LOCK_TIMEOUT : HOLDOFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_UP      = 2'd2,
    ST_HOLDOFF = 2'd3
  } lane_state_e;

  lane_state_e          state_q [NUM_LANES];
  lane_state_e          state_d [NUM_LANES];
  logic [TW-1:0]        timer_q [NUM_LANES];
  logic [TW-1:0]        timer_d [NUM_LANES];
  logic [NUM_LANES-1:0] loss_set;
  logic [NUM_LANES-1:0] retry_evt;

  logic [NUM_LANES-1:0] passthrough_q;
  logic [NUM_LANES-1:0] lane_up_q;
  logic                 all_up_q;
  logic [NUM_LANES-1:0] lock_loss_q;

  // Per-lane next state, timer, loss and retry-event decode.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      state_d[i]   = state_q[i];
      timer_d[i]   = timer_q[i];
      loss_set[i]  = 1'b0;
      retry_evt[i] = 1'b0;
      if (!ENABLE) begin
        // Disable overrides everything: no loss, no retry event.
        state_d[i] = ST_IDLE;
        timer_d[i] = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (BLOCK_LOCK[i]) begin
              state_d[i] = ST_ACQUIRE;
              timer_d[i] = '0;
            end
          end
          ST_ACQUIRE: begin
            if (!BLOCK_LOCK[i]) begin
              state_d[i] = ST_IDLE;
              timer_d[i] = '0;
            end else if (DESCR_LOCKED[i]) begin
              state_d[i] = ST_UP;
            end else if (timer_q[i] == TW'(LOCK_TIMEOUT - 1)) begin
              state_d[i]   = ST_HOLDOFF;
              timer_d[i]   = '0;
              retry_evt[i] = 1'b1;
            end else begin
              timer_d[i] = timer_q[i] + 1'b1;
            end
          end
          ST_UP: begin
            if (!DESCR_LOCKED[i] || !BLOCK_LOCK[i]) begin
              state_d[i]   = ST_HOLDOFF;
              timer_d[i]   = '0;
              loss_set[i]  = 1'b1;
              retry_evt[i] = 1'b1;
            end
          end
          ST_HOLDOFF: begin
            // DESCR_LOCKED is deliberately ignored here: it may be stale.
            if (timer_q[i] == TW'(HOLDOFF_CYCLES - 1)) begin
              state_d[i] = ST_IDLE;
              timer_d[i] = '0;
            end else begin
              timer_d[i] = timer_q[i] + 1'b1;
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            timer_d[i] = '0;
          end
        endcase
      end
    end
  end

  // State, timers and registered status outputs.
  always_ff @(posedge USER_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (SYSTEM_RESET) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= ST_IDLE;
        timer_q[i] <= '0;
      end
      passthrough_q <= '1;
      lane_up_q     <= '0;
      all_up_q      <= 1'b0;
      lock_loss_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        // Passthrough follows the current state (one cycle behind entry),
        // except that a disable forces it high immediately.
        passthrough_q[i] <= !ENABLE || (state_q[i] == ST_IDLE) ||
                            (state_q[i] == ST_HOLDOFF);
        lane_up_q[i]     <= (state_d[i] == ST_UP);
      end
      all_up_q    <= &lane_up_q;
      // A new loss in the same cycle as a clear survives the clear.
      lock_loss_q <= (CLEAR_STICKY ? '0 : lock_loss_q) | loss_set;
    end
  end

  assign PASSTHROUGH  = passthrough_q;
  assign LANE_UP      = lane_up_q;
  assign ALL_LANES_UP = all_up_q;
  assign LOCK_LOSS    = lock_loss_q;

`ifdef LANE_SYNC_RETRY_CNT_EN
  logic [7:0] retry_cnt_q [NUM_LANES];

  // Per-lane saturating retry counters; a coincident event wins over clear.
  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      // NOTE: this array is a few flops read as status, not a RAM, so it is
      // reset like any other register.
      for (int i = 0; i < NUM_LANES; i++) retry_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (CLEAR_STICKY) begin
          retry_cnt_q[i] <= {7'd0, retry_evt[i]};
        end else if (retry_evt[i] && (retry_cnt_q[i] != 8'hFF)) begin
          retry_cnt_q[i] <= retry_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_retry
    assign RETRY_CNT[8*g +: 8] = retry_cnt_q[g];
  end
`endif

endmodule
